nvram_arbiter: RTL and testbench

Sequencer and arbiter sharing one single-port 8 KiB NVRAM between the 68070 CPU bus (chip-select window 0x32xxxx, upper byte lane) and the HPS backup/restore channel. It converts the level-held CPU bus cycle into exactly one RAM access plus a one-cycle `cpu_bus_ack` pulse. It serves HPS requests through a req/ack handshake, round-robins between the two sides under contention, and keeps a dirty flag for the backup path. It sits in `cditop` between the bus decode and the NVRAM array, replacing the dual-port memory with a single-port one.

---
 rtl/nvram_arb_pkg.sv | 18 +
 rtl/nvram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_nvram_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvram_arb_pkg.sv
// Shared types and constants for the NVRAM CPU/HPS arbiter.
package nvram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_HPS_RD,
    ST_ACK
  } nvram_arb_state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_HPS
  } nvram_arb_owner_e;

  localparam logic [7:0] NVRAM_DISABLED_READ = 8'hFF;

endpackage

// File: rtl/nvram_arbiter.sv
// Single-port NVRAM sequencer: turns level-held CPU bus cycles and HPS req/ack
// requests into one RAM access each, round-robin under contention.
module nvram_arbiter
  import nvram_arb_pkg::*;
#(
  parameter int unsigned AW = 13
) (
  input  logic          clk30,
  input  logic          reset,
  input  logic          cpu_cs,
  input  logic          cpu_uds,
  input  logic          cpu_write_strobe,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_enable,
  output logic [7:0]    cpu_dout,
  output logic          cpu_bus_ack,
  input  logic          hps_req,
  input  logic          hps_we,
  input  logic [AW-1:0] hps_addr,
  input  logic [7:0]    hps_din,
  output logic [7:0]    hps_dout,
  output logic          hps_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          dirty,
  input  logic          dirty_clr
);

  nvram_arb_state_e r_state, w_state_nxt;
  nvram_arb_owner_e r_owner, w_owner_nxt;
  nvram_arb_owner_e r_rr_last;

  logic          r_cpu_served, r_hps_served;
  logic          r_cpu_ack, r_hps_ack;
  logic          r_dirty;
  logic [7:0]    r_cpu_dout, r_hps_dout;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata;

  logic          w_cpu_pend, w_hps_pend;
  logic          w_grant_cpu, w_grant_hps;
  logic          w_ram_we, w_cpu_wr, w_cpu_dis_rd;
  logic          w_cpu_ack_nxt, w_hps_ack_nxt;
  logic [AW-1:0] w_ram_addr;
  logic [7:0]    w_ram_wdata;

  // Requests are masked during reset so the RAM port shows its reset values.
  assign w_cpu_pend = cpu_cs && cpu_uds && !r_cpu_served && !reset;
  assign w_hps_pend = hps_req && !r_hps_served && !reset;

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_grant_cpu   = 1'b0;
    w_grant_hps   = 1'b0;
    w_ram_we      = 1'b0;
    w_ram_addr    = r_addr;
    w_ram_wdata   = r_wdata;
    w_cpu_wr      = 1'b0;
    w_cpu_dis_rd  = 1'b0;
    w_cpu_ack_nxt = 1'b0;
    w_hps_ack_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cpu_pend && (!w_hps_pend || r_rr_last == OWN_HPS)) begin
          w_grant_cpu = 1'b1;
        end else if (w_hps_pend) begin
          w_grant_hps = 1'b1;
        end
        if (w_grant_cpu) begin
          w_owner_nxt = OWN_CPU;
          if (!cpu_enable) begin
            // Disabled window: acknowledge without touching the RAM.
            w_state_nxt   = ST_ACK;
            w_cpu_ack_nxt = 1'b1;
            w_cpu_dis_rd  = !cpu_write_strobe;
          end else if (cpu_write_strobe) begin
            w_ram_we      = 1'b1;
            w_ram_addr    = cpu_addr;
            w_ram_wdata   = cpu_din;
            w_cpu_wr      = 1'b1;
            w_state_nxt   = ST_ACK;
            w_cpu_ack_nxt = 1'b1;
          end else begin
            w_ram_addr  = cpu_addr;
            w_state_nxt = ST_CPU_RD;
          end
        end else if (w_grant_hps) begin
          w_owner_nxt = OWN_HPS;
          w_ram_addr  = hps_addr;
          if (hps_we) begin
            w_ram_we      = 1'b1;
            w_ram_wdata   = hps_din;
            w_state_nxt   = ST_ACK;
            w_hps_ack_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_HPS_RD;
          end
        end
      end
      ST_CPU_RD: begin
        w_state_nxt   = ST_ACK;
        w_cpu_ack_nxt = 1'b1;
      end
      ST_HPS_RD: begin
        w_state_nxt   = ST_ACK;
        w_hps_ack_nxt = 1'b1;
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk30 or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_CPU;
      r_rr_last <= OWN_HPS;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cpu_ack <= 1'b0;
      r_hps_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_addr    <= w_ram_addr;
      r_wdata   <= w_ram_wdata;
      r_cpu_ack <= w_cpu_ack_nxt;
      r_hps_ack <= w_hps_ack_nxt;
      if (r_state == ST_ACK) r_rr_last <= r_owner;
    end
  end

  // Served flags, dirty tracking and read-data capture.
  always_ff @(posedge clk30 or posedge reset) begin
    if (reset) begin
      r_cpu_served <= 1'b0;
      r_hps_served <= 1'b0;
      r_dirty      <= 1'b0;
      r_cpu_dout   <= 8'h00;
      r_hps_dout   <= 8'h00;
    end else begin
      if (!cpu_cs)        r_cpu_served <= 1'b0;
      else if (r_cpu_ack) r_cpu_served <= 1'b1;
      if (!hps_req)       r_hps_served <= 1'b0;
      else if (r_hps_ack) r_hps_served <= 1'b1;
      if (w_cpu_wr)       r_dirty <= 1'b1;
      else if (dirty_clr) r_dirty <= 1'b0;
      if (r_state == ST_CPU_RD) r_cpu_dout <= ram_rdata;
      else if (w_cpu_dis_rd)    r_cpu_dout <= NVRAM_DISABLED_READ;
      if (r_state == ST_HPS_RD) r_hps_dout <= ram_rdata;
    end
  end

  assign cpu_dout    = r_cpu_dout;
  assign cpu_bus_ack = r_cpu_ack;
  assign hps_dout    = r_hps_dout;
  assign hps_ack     = r_hps_ack;
  assign ram_addr    = w_ram_addr;
  assign ram_we      = w_ram_we;
  assign ram_wdata   = w_ram_wdata;
  assign dirty       = r_dirty;

endmodule

// File: tb/tb_nvram_arbiter.sv
// Scoreboard bench for nvram_arbiter with a behavioural single-port RAM.
module tb_nvram_arbiter;

  localparam int unsigned AW = 13;

  logic          clk30 = 1'b0;
  logic          reset;
  logic          cpu_cs, cpu_uds, cpu_write_strobe, cpu_enable;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din, cpu_dout;
  logic          cpu_bus_ack;
  logic          hps_req, hps_we;
  logic [AW-1:0] hps_addr;
  logic [7:0]    hps_din, hps_dout;
  logic          hps_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata, ram_rdata;
  logic          dirty, dirty_clr;

  nvram_arbiter #(.AW(AW)) dut (
    .clk30(clk30), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_uds(cpu_uds), .cpu_write_strobe(cpu_write_strobe),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_enable(cpu_enable),
    .cpu_dout(cpu_dout), .cpu_bus_ack(cpu_bus_ack),
    .hps_req(hps_req), .hps_we(hps_we), .hps_addr(hps_addr), .hps_din(hps_din),
    .hps_dout(hps_dout), .hps_ack(hps_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dirty(dirty), .dirty_clr(dirty_clr)
  );

  always #5 clk30 = ~clk30;

  logic [7:0] mem    [0:(1<<AW)-1];
  logic [7:0] shadow [0:(1<<AW)-1];

  always @(posedge clk30) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk30) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int cyc; } obs_t;
  typedef struct { logic rd; logic [7:0] data; int c0; int lat; } exp_t;

  obs_t cpu_obs[$];
  obs_t hps_obs[$];
  exp_t cpu_exp[$];
  exp_t hps_exp[$];
  int   cpu_idx = 0;
  int   hps_idx = 0;
  int   checks = 0;
  int   failures = 0;

  // Ack monitor: records every ack pulse with its data and cycle stamp.
  always @(negedge clk30) begin
    if (cpu_bus_ack) cpu_obs.push_back('{cpu_dout, cyc});
    if (hps_ack)     hps_obs.push_back('{hps_dout, cyc});
  end

  task automatic cpu_start(input logic we, input logic [AW-1:0] a, input logic [7:0] d, input int lat);
    logic [7:0] ed;
    cpu_cs = 1'b1; cpu_uds = 1'b1; cpu_write_strobe = we; cpu_addr = a; cpu_din = d;
    if (!cpu_enable)  ed = we ? 8'h00 : 8'hFF;
    else if (we)      begin shadow[a] = d; ed = d; end
    else              ed = shadow[a];
    cpu_exp.push_back('{!we, ed, cyc, lat});
  endtask

  task automatic hps_start(input logic we, input logic [AW-1:0] a, input logic [7:0] d, input int lat);
    hps_req = 1'b1; hps_we = we; hps_addr = a; hps_din = d;
    if (we) shadow[a] = d;
    hps_exp.push_back('{!we, shadow[a], cyc, lat});
  endtask

  task automatic wait_acks(input int nc, input int nh, output bit ok);
    for (int k = 0; k < 100; k++) begin
      if (cpu_obs.size() >= cpu_idx + nc && hps_obs.size() >= hps_idx + nh) break;
      @(posedge clk30);
    end
    ok = (cpu_obs.size() >= cpu_idx + nc && hps_obs.size() >= hps_idx + nh);
  endtask

  task automatic pop_cpu(output exp_t e, output obs_t o);
    e = cpu_exp.pop_front(); o = cpu_obs[cpu_idx]; cpu_idx++;
  endtask

  task automatic pop_hps(output exp_t e, output obs_t o);
    e = hps_exp.pop_front(); o = hps_obs[hps_idx]; hps_idx++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk30);
    checks++;
    if ({cpu_bus_ack, hps_ack, ram_we, ram_addr, ram_wdata, cpu_dout, hps_dout, dirty} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b/%b we=%b addr=%h wd=%h cd=%h hd=%h dirty=%b expected all zero",
               cpu_bus_ack, hps_ack, ram_we, ram_addr, ram_wdata, cpu_dout, hps_dout, dirty);
    end
    reset = 1'b0;
    @(negedge clk30);
    checks++;
    if ({cpu_bus_ack, hps_ack, ram_we, dirty} !== 4'b0) begin
      failures++;
      $display("FAIL reset_release_idle: got %b expected 0000", {cpu_bus_ack, hps_ack, ram_we, dirty});
    end
  endtask

  task automatic test_cpu_basic();
    exp_t e; obs_t o; bit ok;
    @(negedge clk30);
    cpu_start(1'b1, 13'h0010, 8'hA5, 1);
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 13'h0010, 8'hA5}) begin
      failures++;
      $display("FAIL cpu_wr_port: got we=%b addr=%h wd=%h expected 1 0010 a5", ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk30);
    checks++;
    if (ram_we !== 1'b0) begin failures++; $display("FAIL cpu_wr_pulse: got ram_we=%b expected 0", ram_we); end
    wait_acks(1, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL cpu_wr_timeout: got no ack expected ack"); end
    else begin
      pop_cpu(e, o);
      if (o.cyc - e.c0 !== e.lat) begin failures++; $display("FAIL cpu_wr_lat: got %0d expected %0d", o.cyc - e.c0, e.lat); end
    end
    checks++;
    if (dirty !== 1'b1) begin failures++; $display("FAIL cpu_wr_dirty: got %b expected 1", dirty); end
    @(negedge clk30); cpu_cs = 1'b0;
    @(negedge clk30);
    cpu_start(1'b0, 13'h0010, 8'h00, 2);
    wait_acks(1, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL cpu_rd_timeout: got no ack expected ack"); end
    else begin
      pop_cpu(e, o);
      if (o.data !== e.data || o.cyc - e.c0 !== e.lat) begin
        failures++;
        $display("FAIL cpu_rd: got data=%h lat=%0d expected data=%h lat=%0d", o.data, o.cyc - e.c0, e.data, e.lat);
      end
    end
    @(negedge clk30); cpu_cs = 1'b0;
  endtask

  task automatic test_hps_restore_backup();
    exp_t e; obs_t o; bit ok;
    @(negedge clk30); dirty_clr = 1'b1;
    @(negedge clk30); dirty_clr = 1'b0;
    checks++;
    if (dirty !== 1'b0) begin failures++; $display("FAIL dirty_clr: got %b expected 0", dirty); end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 256; i++) begin
        @(negedge clk30);
        hps_start(pass == 0, AW'(i), 8'(i), (pass == 0) ? 1 : 2);
        wait_acks(0, 1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL hps_timeout: got no ack at addr %0d expected ack", i); end
        else begin
          pop_hps(e, o);
          if ((e.rd && o.data !== e.data) || o.cyc - e.c0 !== e.lat) begin
            failures++;
            $display("FAIL hps_access: addr %0d got data=%h lat=%0d expected data=%h lat=%0d",
                     i, o.data, o.cyc - e.c0, e.data, e.lat);
          end
        end
        @(negedge clk30); hps_req = 1'b0;
      end
    end
    checks++;
    if (dirty !== 1'b0) begin failures++; $display("FAIL hps_dirty: got %b expected 0", dirty); end
  endtask

  task automatic test_collision();
    exp_t e; obs_t o; bit ok;
    for (int round = 0; round < 2; round++) begin
      @(negedge clk30);
      cpu_start(1'b0, 13'h0010, 8'h00, (round == 0) ? 2 : 5);
      hps_start(1'b0, 13'h0005, 8'h00, (round == 0) ? 5 : 2);
      wait_acks(1, 1, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL collide_timeout: round %0d missing ack", round); end
      else begin
        pop_cpu(e, o);
        if (o.data !== e.data || o.cyc - e.c0 !== e.lat) begin
          failures++;
          $display("FAIL collide_cpu: round %0d got data=%h lat=%0d expected data=%h lat=%0d",
                   round, o.data, o.cyc - e.c0, e.data, e.lat);
        end
        pop_hps(e, o);
        if (o.data !== e.data || o.cyc - e.c0 !== e.lat) begin
          failures++;
          $display("FAIL collide_hps: round %0d got data=%h lat=%0d expected data=%h lat=%0d",
                   round, o.data, o.cyc - e.c0, e.data, e.lat);
        end
      end
      @(negedge clk30); cpu_cs = 1'b0; hps_req = 1'b0;
      if (round == 0) begin
        // A lone CPU grant makes the CPU the last owner, so HPS wins next.
        @(negedge clk30);
        cpu_start(1'b0, 13'h0010, 8'h00, 2);
        wait_acks(1, 0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL lone_cpu_timeout: got no ack expected ack"); end
        else begin
          pop_cpu(e, o);
          if (o.data !== e.data) begin failures++; $display("FAIL lone_cpu: got %h expected %h", o.data, e.data); end
        end
        @(negedge clk30); cpu_cs = 1'b0;
      end
    end
  endtask

  task automatic test_disabled();
    exp_t e; obs_t o; bit ok;
    cpu_enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk30);
      cpu_start(k == 0, 13'h0020, 8'h3C, 1);
      #1;
      checks++;
      if (ram_we !== 1'b0) begin failures++; $display("FAIL dis_ram_we: got %b expected 0", ram_we); end
      wait_acks(1, 0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL dis_timeout: access %0d got no ack expected ack", k); end
      else begin
        pop_cpu(e, o);
        if ((e.rd && o.data !== e.data) || o.cyc - e.c0 !== e.lat) begin
          failures++;
          $display("FAIL dis_access: %0d got data=%h lat=%0d expected data=%h lat=%0d",
                   k, o.data, o.cyc - e.c0, e.data, e.lat);
        end
      end
      @(negedge clk30); cpu_cs = 1'b0;
    end
    checks++;
    if (dirty !== 1'b0) begin failures++; $display("FAIL dis_dirty: got %b expected 0", dirty); end
    cpu_enable = 1'b1;
    @(negedge clk30);
    cpu_start(1'b0, 13'h0020, 8'h00, 2);
    wait_acks(1, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL dis_readback_timeout: got no ack expected ack"); end
    else begin
      pop_cpu(e, o);
      if (o.data !== e.data) begin failures++; $display("FAIL dis_readback: got %h expected %h", o.data, e.data); end
    end
    @(negedge clk30); cpu_cs = 1'b0;
  endtask

  task automatic test_hold_and_dirty();
    exp_t e; obs_t o; bit ok;
    @(negedge clk30);
    cpu_start(1'b0, 13'h0030, 8'h00, 2);
    repeat (20) @(negedge clk30);
    checks++;
    if (cpu_obs.size() - cpu_idx !== 1) begin
      failures++;
      $display("FAIL hold_one_ack: got %0d acks expected 1", cpu_obs.size() - cpu_idx);
    end
    else begin
      pop_cpu(e, o);
      checks++;
      if (o.data !== e.data) begin failures++; $display("FAIL hold_data: got %h expected %h", o.data, e.data); end
    end
    cpu_cs = 1'b0;
    @(negedge clk30);
    cpu_start(1'b1, 13'h0040, 8'h77, 1);
    dirty_clr = 1'b1;
    @(negedge clk30); dirty_clr = 1'b0;
    checks++;
    if (dirty !== 1'b1) begin failures++; $display("FAIL dirty_set_wins: got %b expected 1", dirty); end
    wait_acks(1, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL dirty_wr_timeout: got no ack expected ack"); end
    else begin
      pop_cpu(e, o);
      if (o.cyc - e.c0 !== e.lat) begin failures++; $display("FAIL dirty_wr_lat: got %0d expected %0d", o.cyc - e.c0, e.lat); end
    end
    @(negedge clk30); cpu_cs = 1'b0;
  endtask

  task automatic test_reset_midread();
    exp_t e; obs_t o; bit ok;
    @(negedge clk30);
    cpu_cs = 1'b1; cpu_uds = 1'b1; cpu_write_strobe = 1'b0; cpu_addr = 13'h0040;
    @(negedge clk30);
    reset = 1'b1;
    #1;
    checks++;
    if ({cpu_bus_ack, hps_ack, ram_we, ram_addr, ram_wdata, cpu_dout, hps_dout, dirty} !== '0) begin
      failures++;
      $display("FAIL midread_reset: got ack=%b/%b we=%b addr=%h wd=%h cd=%h hd=%h dirty=%b expected all zero",
               cpu_bus_ack, hps_ack, ram_we, ram_addr, ram_wdata, cpu_dout, hps_dout, dirty);
    end
    repeat (3) @(negedge clk30);
    checks++;
    if (cpu_obs.size() !== cpu_idx) begin failures++; $display("FAIL midread_no_ack: got %0d acks expected 0", cpu_obs.size() - cpu_idx); end
    reset = 1'b0;
    cpu_exp.push_back('{1'b1, shadow[13'h0040], cyc, 2});
    wait_acks(1, 0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reserve_timeout: got no ack expected ack"); end
    else begin
      pop_cpu(e, o);
      if (o.data !== e.data || o.cyc - e.c0 !== e.lat) begin
        failures++;
        $display("FAIL reserve: got data=%h lat=%0d expected data=%h lat=%0d", o.data, o.cyc - e.c0, e.data, e.lat);
      end
    end
    repeat (10) @(negedge clk30);
    checks++;
    if (cpu_obs.size() !== cpu_idx) begin failures++; $display("FAIL reserve_once: got %0d extra acks expected 0", cpu_obs.size() - cpu_idx); end
    cpu_cs = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_cs = 1'b0; cpu_uds = 1'b0; cpu_write_strobe = 1'b0; cpu_addr = '0; cpu_din = '0;
    cpu_enable = 1'b1;
    hps_req = 1'b0; hps_we = 1'b0; hps_addr = '0; hps_din = '0;
    dirty_clr = 1'b0;
    test_reset();
    test_cpu_basic();
    test_hps_restore_backup();
    test_collision();
    test_disabled();
    test_hold_and_dirty();
    test_reset_midread();
    repeat (3) @(negedge clk30);
    checks++;
    if (cpu_obs.size() !== cpu_idx || hps_obs.size() !== hps_idx) begin
      failures++;
      $display("FAIL stray_acks: got cpu=%0d hps=%0d unexpected acks expected 0",
               cpu_obs.size() - cpu_idx, hps_obs.size() - hps_idx);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
